xpb_lut_loadable: RTL and testbench

//  Runtime-loadable successor to the fixed xpb_* constant tables. Holds 2**SEL_BITS

---
 rtl/xpb_lut_loadable.sv | 86 ++++++++
 tb/tb_xpb_lut_loadable.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/xpb_lut_loadable.sv
// xpb_lut_loadable: runtime-loadable table of reduction multiples, streamed in chunk by chunk
// and served to NUM_LANES independent registered lookups per cycle.
module xpb_lut_loadable #(
  parameter int SEL_BITS   = 5,
  parameter int WORD_BITS  = 1024,
  parameter int CHUNK_BITS = 64,
  parameter int NUM_LANES  = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load_start,
  input  logic                           load_valid,
  input  logic [CHUNK_BITS-1:0]          load_data,
  output logic                           load_ready,
  output logic                           table_valid,
  input  logic                           lookup_valid,
  input  logic [NUM_LANES*SEL_BITS-1:0]  lookup_sel,
  output logic                           result_valid,
  output logic [NUM_LANES*WORD_BITS-1:0] result_data,
  output logic                           lookup_miss
);
  localparam int CPC = WORD_BITS / CHUNK_BITS;
  localparam int CW = CPC > 1 ? $clog2(CPC) : 1;
  localparam int DEPTH = 2 ** SEL_BITS;
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, READY = 2'd2;
  localparam logic [SEL_BITS-1:0] LAST_ENT = '1;
  localparam logic [CW-1:0] LAST_CHK = CW'(CPC - 1);

  logic [1:0]                     r_state;
  logic [SEL_BITS-1:0]            r_entry;
  logic [CW-1:0]                  r_chunk;
  logic [WORD_BITS-1:0]           r_mem [DEPTH];
  logic                           r_result_valid;
  logic                           r_lookup_miss;
  logic [NUM_LANES*WORD_BITS-1:0] r_result_data;
  logic                           w_acc;
  logic                           w_last;
  logic                           w_wrap;
  logic                           w_hit;

  assign load_ready   = r_state == LOAD;
  assign table_valid  = r_state == READY;
  assign result_valid = r_result_valid;
  assign lookup_miss  = r_lookup_miss;
  assign result_data  = r_result_data;
  // load_start wins: a chunk presented alongside it is dropped
  assign w_acc  = load_valid && load_ready && !load_start;
  assign w_wrap = r_chunk == LAST_CHK;
  assign w_last = r_entry == LAST_ENT && w_wrap;
  assign w_hit  = lookup_valid && table_valid;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_entry <= '0;
      r_chunk <= '0;
    end else if (load_start) begin
      r_state <= LOAD;
      r_entry <= SEL_BITS'(1);
      r_chunk <= '0;
    end else if (w_acc) begin
      r_state <= w_last ? READY : LOAD;
      r_chunk <= w_wrap ? '0 : r_chunk + 1'b1;
      r_entry <= r_entry + SEL_BITS'(w_wrap);
    end

  // Storage is deliberately left unreset; entry 0 is never written and reads as zero
  always_ff @(posedge clk)
    if (w_acc)
      for (int c = 0; c < CPC; c++)
        if (r_chunk == CW'(c)) r_mem[r_entry][c*CHUNK_BITS +: CHUNK_BITS] <= load_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_result_valid <= 1'b0;
      r_lookup_miss  <= 1'b0;
      r_result_data  <= '0;
    end else begin
      r_result_valid <= w_hit;
      r_lookup_miss  <= lookup_valid && !table_valid;
      if (w_hit)
        for (int i = 0; i < NUM_LANES; i++)
          r_result_data[i*WORD_BITS +: WORD_BITS] <= lookup_sel[i*SEL_BITS +: SEL_BITS] == '0 ?
            '0 : r_mem[lookup_sel[i*SEL_BITS +: SEL_BITS]];
    end
endmodule

// File: tb/tb_xpb_lut_loadable.sv
// tb_xpb_lut_loadable: directed checks on a tiny 4x16-bit table plus a randomised run
// of the default 32x1024-bit configuration against a reference array.
module tb_xpb_lut_loadable;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic        s_start = 0, s_lv = 0, s_luv = 0;
  logic [7:0]  s_ld = '0;
  logic [3:0]  s_sel = '0;
  logic        s_ready, s_tv, s_rv, s_miss;
  logic [31:0] s_rd;

  xpb_lut_loadable #(.SEL_BITS(2), .WORD_BITS(16), .CHUNK_BITS(8), .NUM_LANES(2)) u_small (
    .clk(clk), .rst_n(rst_n), .load_start(s_start), .load_valid(s_lv), .load_data(s_ld),
    .load_ready(s_ready), .table_valid(s_tv), .lookup_valid(s_luv), .lookup_sel(s_sel),
    .result_valid(s_rv), .result_data(s_rd), .lookup_miss(s_miss));

  logic          b_start = 0, b_lv = 0, b_luv = 0;
  logic [63:0]   b_ld = '0;
  logic [9:0]    b_sel = '0;
  logic          b_ready, b_tv, b_rv, b_miss;
  logic [2047:0] b_rd;

  xpb_lut_loadable u_big (
    .clk(clk), .rst_n(rst_n), .load_start(b_start), .load_valid(b_lv), .load_data(b_ld),
    .load_ready(b_ready), .table_valid(b_tv), .lookup_valid(b_luv), .lookup_sel(b_sel),
    .result_valid(b_rv), .result_data(b_rd), .lookup_miss(b_miss));

  typedef struct {
    logic        luv;
    logic [1:0]  s0, s1;
    logic        ev;
    logic [15:0] e0, e1;
  } vec_t;
  vec_t vecs [6];

  logic [1023:0] mdl [32];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Loads entries 1..3; the start cycle also carries a junk chunk that must be dropped
  task automatic load3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    logic [7:0] ch [6];
    ch = '{a[7:0], a[15:8], b[7:0], b[15:8], c[7:0], c[15:8]};
    s_start = 1; s_lv = 1; s_ld = 8'hEE;
    tick;
    s_start = 0;
    chk("load_ready_in_load", {63'd0, s_ready}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) chk("tv_before_last", {63'd0, s_tv}, 64'd0);
      s_ld = ch[i];
      tick;
    end
    s_lv = 0;
    chk("tv_after_last", {63'd0, s_tv}, 64'd1);
    chk("ready_after_last", {63'd0, s_ready}, 64'd0);
  endtask

  task automatic lookup2(input string n, input logic [1:0] a, input logic [1:0] b,
                         input logic [15:0] ea, input logic [15:0] eb);
    s_luv = 1; s_sel = {b, a};
    tick;
    s_luv = 0;
    chk({n, "_rv"}, {63'd0, s_rv}, 64'd1);
    chk({n, "_miss"}, {63'd0, s_miss}, 64'd0);
    chk({n, "_data"}, {32'd0, s_rd}, {32'd0, eb, ea});
  endtask

  initial begin
    vecs[0] = '{1, 2'd3, 2'd0, 1, 16'h9ABC, 16'h0000};
    vecs[1] = '{1, 2'd1, 2'd1, 1, 16'h1234, 16'h1234};
    vecs[2] = '{1, 2'd2, 2'd3, 1, 16'h5678, 16'h9ABC};
    vecs[3] = '{0, 2'd1, 2'd1, 0, 16'h5678, 16'h9ABC};
    vecs[4] = '{1, 2'd0, 2'd0, 1, 16'h0000, 16'h0000};
    vecs[5] = '{1, 2'd3, 2'd2, 1, 16'h9ABC, 16'h5678};

    // T1: reset values and a lookup before any load
    repeat (3) tick;
    rst_n = 1;
    tick;
    chk("rst_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_tv", {63'd0, s_tv}, 64'd0);
    chk("rst_rv", {63'd0, s_rv}, 64'd0);
    chk("rst_miss", {63'd0, s_miss}, 64'd0);
    chk("rst_data", {32'd0, s_rd}, 64'd0);
    s_luv = 1; s_sel = {2'd2, 2'd1};
    tick;
    s_luv = 0;
    chk("t1_miss", {63'd0, s_miss}, 64'd1);
    chk("t1_rv", {63'd0, s_rv}, 64'd0);
    chk("t1_data", {32'd0, s_rd}, 64'd0);
    tick;
    chk("t1_miss_pulse", {63'd0, s_miss}, 64'd0);

    // T2: full load; a chunk presented in READY is ignored
    load3(16'h1234, 16'h5678, 16'h9ABC);
    s_lv = 1; s_ld = 8'hFF;
    tick;
    s_lv = 0;
    chk("t2_tv_hold", {63'd0, s_tv}, 64'd1);

    // T3: table-driven lookups including back-to-back and hold-on-idle
    foreach (vecs[i]) begin
      s_luv = vecs[i].luv; s_sel = {vecs[i].s1, vecs[i].s0};
      tick;
      chk($sformatf("t3_rv[%0d]", i), {63'd0, s_rv}, {63'd0, vecs[i].ev});
      chk($sformatf("t3_data[%0d]", i), {32'd0, s_rd}, {32'd0, vecs[i].e1, vecs[i].e0});
    end
    s_luv = 0;

    // load_start with a lookup in READY: old contents returned, table_valid drops
    s_start = 1; s_luv = 1; s_sel = {2'd2, 2'd1};
    tick;
    s_start = 0; s_luv = 0;
    chk("rs_rv", {63'd0, s_rv}, 64'd1);
    chk("rs_data", {32'd0, s_rd}, {32'd0, 16'h5678, 16'h1234});
    chk("rs_tv", {63'd0, s_tv}, 64'd0);

    // T4: three chunks of an aborted load (one with a lookup that must miss), then restart
    for (int i = 0; i < 3; i++) begin
      s_lv = 1; s_ld = 8'hA0 + 8'(i); s_luv = (i == 0);
      tick;
      if (i == 0) chk("t4_miss_in_load", {63'd0, s_miss}, 64'd1);
    end
    s_lv = 0; s_luv = 0;
    load3(16'h1111, 16'h2222, 16'h3333);
    lookup2("t4_a", 2'd1, 2'd3, 16'h1111, 16'h3333);
    lookup2("t4_b", 2'd2, 2'd2, 16'h2222, 16'h2222);

    // T5: async reset in the middle of a reload
    s_start = 1;
    tick;
    s_start = 0;
    for (int i = 0; i < 4; i++) begin
      s_lv = 1; s_ld = 8'h50 + 8'(i);
      tick;
    end
    s_lv = 0;
    rst_n = 0;
    #2;
    chk("t5_ready", {63'd0, s_ready}, 64'd0);
    chk("t5_tv", {63'd0, s_tv}, 64'd0);
    chk("t5_rv", {63'd0, s_rv}, 64'd0);
    chk("t5_miss", {63'd0, s_miss}, 64'd0);
    chk("t5_data", {32'd0, s_rd}, 64'd0);
    #3;
    rst_n = 1;
    tick;
    s_luv = 1; s_sel = {2'd1, 2'd1};
    tick;
    s_luv = 0;
    chk("t5_miss_after", {63'd0, s_miss}, 64'd1);
    chk("t5_rv_after", {63'd0, s_rv}, 64'd0);
    load3(16'h4444, 16'h5555, 16'h6666);
    lookup2("t5_reload", 2'd3, 2'd1, 16'h6666, 16'h4444);

    // T6: default configuration, random table, random lookups
    mdl[0] = '0;
    for (int e = 1; e < 32; e++)
      for (int w = 0; w < 32; w++) mdl[e][w*32 +: 32] = $urandom;
    b_start = 1;
    tick;
    b_start = 0;
    for (int e = 1; e < 32; e++)
      for (int c = 0; c < 16; c++) begin
        if (!b_ready) begin
          errors++;
          $display("FAIL t6_ready: got 0 expected 1 at entry %0d chunk %0d", e, c);
        end
        b_lv = 1; b_ld = mdl[e][c*64 +: 64];
        tick;
      end
    b_lv = 0;
    chk("t6_tv", {63'd0, b_tv}, 64'd1);
    chk("t6_ready", {63'd0, b_ready}, 64'd0);
    begin
      logic [2047:0] exp_rd;
      logic [4:0] s0, s1;
      exp_rd = '0;
      for (int n = 0; n < 1000; n++) begin
        s0 = 5'($urandom_range(0, 31));
        s1 = (n % 7 == 0) ? s0 : 5'($urandom_range(0, 31));
        b_luv = (n % 10 != 9); b_sel = {s1, s0};
        if (b_luv) exp_rd = {mdl[s1], mdl[s0]};
        tick;
        checks++;
        if (b_rv !== b_luv || b_rd !== exp_rd) begin
          errors++;
          $display("FAIL t6_lookup[%0d]: sel %0d/%0d rv %b lo %h, expected rv %b lo %h",
                   n, s0, s1, b_rv, b_rd[63:0], b_luv, exp_rd[63:0]);
        end
      end
    end
    b_luv = 0;
    b_start = 1;
    tick;
    b_start = 0;
    chk("t6_tv_drop", {63'd0, b_tv}, 64'd0);
    chk("t6_ready_reload", {63'd0, b_ready}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
